// File: rtl/call_return_ctrl.sv
// Call/return sequencer: turns CALL/RET requests into return-address stack
// push/pop operations and PC loads, refusing requests the stack cannot take.
module call_return_ctrl #(
    parameter int unsigned AW = 10,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic [AW-1:0] call_target,
    input  logic [AW-1:0] ret_addr,
    output logic          stk_enable,
    output logic          stk_operation,
    output logic [AW-1:0] stk_data_in,
    input  logic [AW-1:0] stk_data_out,
    input  logic          stk_full,
    input  logic          stk_empty,
    output logic          pc_load,
    output logic [AW-1:0] pc_value,
    output logic          done,
    output logic          err_ovf,
    output logic          err_udf,
    input  logic          err_clr,
    output logic [CW-1:0] depth,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_LOAD,
        S_FAULT,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic          stk_enable_q, stk_enable_d;
    logic          stk_operation_q, stk_operation_d;
    logic [AW-1:0] stk_data_in_q, stk_data_in_d;
    logic          pc_load_q, pc_load_d;
    logic [AW-1:0] pc_value_q, pc_value_d;
    logic          done_q, done_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_udf_q, err_udf_d;
    logic [CW-1:0] depth_q, depth_d;
    logic          busy_q, busy_d;

    // Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_d         = state_q;
        stk_enable_d    = 1'b0;
        stk_operation_d = 1'b0;
        stk_data_in_d   = '0;
        pc_load_d       = 1'b0;
        pc_value_d      = '0;
        done_d          = 1'b0;
        err_ovf_d       = err_ovf_q;
        err_udf_d       = err_udf_q;
        depth_d         = depth_q;

        case (state_q)
            S_IDLE: begin
                if (call_req) begin
                    if (!stk_full) begin
                        state_d         = S_PUSH;
                        stk_enable_d    = 1'b1;
                        stk_operation_d = 1'b1;
                        stk_data_in_d   = ret_addr;
                        pc_load_d       = 1'b1;
                        pc_value_d      = call_target;
                        done_d          = 1'b1;
                        depth_d         = depth_q + CW'(1);
                    end else begin
                        state_d   = S_FAULT;
                        err_ovf_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end else if (ret_req) begin
                    if (!stk_empty) begin
                        state_d      = S_POP;
                        stk_enable_d = 1'b1;
                        depth_d      = depth_q - CW'(1);
                    end else begin
                        state_d   = S_FAULT;
                        err_udf_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            S_PUSH: state_d = S_RELEASE;
            S_POP: begin
                // Popped data is only valid once LOAD starts; pc_value muxes it in.
                state_d   = S_LOAD;
                pc_load_d = 1'b1;
                done_d    = 1'b1;
            end
            S_LOAD:  state_d = S_RELEASE;
            S_FAULT: state_d = S_RELEASE;
            S_RELEASE: begin
                if (!call_req && !ret_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A clear in the same cycle as a refusal wins.
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_udf_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            stk_enable_q    <= 1'b0;
            stk_operation_q <= 1'b0;
            stk_data_in_q   <= '0;
            pc_load_q       <= 1'b0;
            pc_value_q      <= '0;
            done_q          <= 1'b0;
            err_ovf_q       <= 1'b0;
            err_udf_q       <= 1'b0;
            depth_q         <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            stk_enable_q    <= stk_enable_d;
            stk_operation_q <= stk_operation_d;
            stk_data_in_q   <= stk_data_in_d;
            pc_load_q       <= pc_load_d;
            pc_value_q      <= pc_value_d;
            done_q          <= done_d;
            err_ovf_q       <= err_ovf_d;
            err_udf_q       <= err_udf_d;
            depth_q         <= depth_d;
            busy_q          <= busy_d;
        end
    end

    assign stk_enable    = stk_enable_q;
    assign stk_operation = stk_operation_q;
    assign stk_data_in   = stk_data_in_q;
    assign pc_load       = pc_load_q;
    assign pc_value      = (state_q == S_LOAD) ? stk_data_out : pc_value_q;
    assign done          = done_q;
    assign err_ovf       = err_ovf_q;
    assign err_udf       = err_udf_q;
    assign depth         = depth_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Bench for call_return_ctrl: an 8-deep stack environment plus a
// transaction-level model predicting every output on every cycle.
module tb_call_return_ctrl;

    localparam int unsigned AW     = 10;
    localparam int unsigned CW     = 5;
    localparam int          SDEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          call_req, ret_req, err_clr;
    logic [AW-1:0] call_target, ret_addr;
    logic          stk_enable, stk_operation;
    logic [AW-1:0] stk_data_in, stk_data_out;
    logic          stk_full, stk_empty;
    logic          pc_load, done, err_ovf, err_udf, busy;
    logic [AW-1:0] pc_value;
    logic [CW-1:0] depth;

    call_return_ctrl #(.AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .call_req(call_req), .ret_req(ret_req),
        .call_target(call_target), .ret_addr(ret_addr),
        .stk_enable(stk_enable), .stk_operation(stk_operation),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .stk_full(stk_full), .stk_empty(stk_empty),
        .pc_load(pc_load), .pc_value(pc_value), .done(done),
        .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr),
        .depth(depth), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment: the return-address stack the controller drives.
    logic [AW-1:0] smem [SDEPTH];
    int            scnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt         <= 0;
            stk_data_out <= '0;
        end else if (stk_enable) begin
            if (stk_operation && scnt < SDEPTH) begin
                smem[scnt[2:0]] <= stk_data_in;
                scnt            <= scnt + 1;
            end else if (!stk_operation && scnt > 0) begin
                stk_data_out <= smem[3'(scnt - 1)];
                scnt         <= scnt - 1;
            end
        end
    end
    assign stk_full  = (scnt == SDEPTH);
    assign stk_empty = (scnt == 0);

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state and per-cycle expectations.
    logic [AW-1:0] m_stk [$];
    logic [AW-1:0] m_pcs [$];
    logic [AW-1:0] dut_pcs [$];
    logic          m_ovf = 1'b0, m_udf = 1'b0;
    logic          exp_en = 1'b0, exp_op = 1'b0, exp_pcl = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
    logic [AW-1:0] exp_din = '0, exp_pcv = '0;
    logic [CW-1:0] exp_depth = '0;

    always @(negedge clk) begin
        check("stk_enable", 32'(stk_enable), 32'(exp_en));
        check("stk_operation", 32'(stk_operation), 32'(exp_op));
        check("stk_data_in", 32'(stk_data_in), 32'(exp_din));
        check("pc_load", 32'(pc_load), 32'(exp_pcl));
        check("pc_value", 32'(pc_value), 32'(exp_pcv));
        check("done", 32'(done), 32'(exp_done));
        check("err_ovf", 32'(err_ovf), 32'(m_ovf));
        check("err_udf", 32'(err_udf), 32'(m_udf));
        check("depth", 32'(depth), 32'(exp_depth));
        check("busy", 32'(busy), 32'(exp_busy));
        if (pc_load === 1'b1) dut_pcs.push_back(pc_value);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_exp();
        exp_en = 1'b0; exp_op = 1'b0; exp_din = '0;
        exp_pcl = 1'b0; exp_pcv = '0; exp_done = 1'b0;
        exp_depth = CW'(m_stk.size());
    endtask

    // One request from an idle cycle; requests dropped 'hold' cycles after done.
    task automatic txn(input logic c, input logic r, input logic [AW-1:0] tgt,
                       input logic [AW-1:0] ra, input int hold, input logic clr);
        logic [AW-1:0] popped;
        bit            two_phase;
        popped = '0;
        two_phase = 1'b0;
        call_req = c; ret_req = r; call_target = tgt; ret_addr = ra; err_clr = clr;
        step();
        err_clr = 1'b0;
        if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
        quiet_exp();
        exp_busy = 1'b1;
        if (c) begin
            if (m_stk.size() < SDEPTH) begin
                exp_en = 1'b1; exp_op = 1'b1; exp_din = ra;
                exp_pcl = 1'b1; exp_pcv = tgt; exp_done = 1'b1;
                m_stk.push_back(ra);
                m_pcs.push_back(tgt);
            end else begin
                if (!clr) m_ovf = 1'b1;
                exp_done = 1'b1;
            end
        end else begin
            if (m_stk.size() > 0) begin
                exp_en = 1'b1;
                popped = m_stk.pop_back();
                two_phase = 1'b1;
            end else begin
                if (!clr) m_udf = 1'b1;
                exp_done = 1'b1;
            end
        end
        exp_depth = CW'(m_stk.size());
        if (two_phase) begin
            step();
            quiet_exp();
            exp_pcl = 1'b1; exp_pcv = popped; exp_done = 1'b1;
            m_pcs.push_back(popped);
        end
        for (int i = 0; i < hold; i++) begin
            step();
            quiet_exp();
        end
        call_req = 1'b0; ret_req = 1'b0;
        step();
        quiet_exp();
        exp_busy = (hold == 0);
        if (hold == 0) begin
            step();
            exp_busy = 1'b0;
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    logic [AW-1:0] lit_pcs [9];

    initial begin
        lit_pcs = '{10'h155, 10'h042, 10'h100, 10'h101, 10'h102,
                    10'h030, 10'h020, 10'h010, 10'h3AA};
        rst_n = 1'b0; call_req = 1'b0; ret_req = 1'b0; err_clr = 1'b0;
        call_target = '0; ret_addr = '0;
        step(); step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset depth", 32'(depth), 32'd0);
        check("reset pc_value", 32'(pc_value), 32'd0);
        rst_n = 1'b1;
        step();

        // Single CALL then RET.
        txn(1'b1, 1'b0, 10'h155, 10'h042, 0, 1'b0);
        check("depth after call", 32'(depth), 32'd1);
        txn(1'b0, 1'b1, 10'h000, 10'h000, 0, 1'b0);
        check("depth after ret", 32'(depth), 32'd0);
        check("stk_empty after ret", 32'(stk_empty), 32'd1);

        // Nested calls unwind in reverse order.
        txn(1'b1, 1'b0, 10'h100, 10'h010, 0, 1'b0);
        txn(1'b1, 1'b0, 10'h101, 10'h020, 1, 1'b0);
        txn(1'b1, 1'b0, 10'h102, 10'h030, 0, 1'b0);
        check("nested depth", 32'(depth), 32'd3);
        for (int i = 0; i < 3; i++) txn(1'b0, 1'b1, 10'h000, 10'h000, 0, 1'b0);

        // RET on empty stack, then sticky clear; then clear racing a new refusal.
        txn(1'b0, 1'b1, 10'h000, 10'h000, 0, 1'b0);
        check("err_udf sticky", 32'(err_udf), 32'd1);
        clear_err();
        check("err_udf cleared", 32'(err_udf), 32'd0);
        txn(1'b0, 1'b1, 10'h000, 10'h000, 0, 1'b1);
        check("err_udf clear wins", 32'(err_udf), 32'd0);

        // Both requests held: exactly one CALL.
        txn(1'b1, 1'b1, 10'h3AA, 10'h155, 4, 1'b0);
        check("one call serviced", 32'(depth), 32'd1);

        // Reset in the middle of a POP.
        ret_req = 1'b1;
        step();
        check("pop reached", 32'(stk_enable), 32'd1);
        #2 rst_n = 1'b0;
        m_stk.delete();
        quiet_exp();
        exp_busy = 1'b0;
        #1;
        check("rst stk_enable", 32'(stk_enable), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst depth", 32'(depth), 32'd0);
        ret_req = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        check("post-reset done", 32'(done), 32'd0);

        // Fill the stack, then a refused CALL.
        for (int i = 0; i < SDEPTH; i++)
            txn(1'b1, 1'b0, AW'(10'h200 + i), AW'(10'h300 + i), 0, 1'b0);
        check("stk_full", 32'(stk_full), 32'd1);
        txn(1'b1, 1'b0, 10'h3FF, 10'h3FE, 0, 1'b0);
        check("err_ovf set", 32'(err_ovf), 32'd1);
        check("depth held on ovf", 32'(depth), 32'd8);
        clear_err();
        check("err_ovf cleared", 32'(err_ovf), 32'd0);
        step();

        // PC load order pinned to literals for both DUT and model.
        for (int i = 0; i < 9; i++) begin
            check($sformatf("model pc[%0d]", i), 32'(m_pcs[i]), 32'(lit_pcs[i]));
            check($sformatf("dut pc[%0d]", i), 32'(dut_pcs[i]), 32'(lit_pcs[i]));
        end
        check("pc load count", 32'(dut_pcs.size()), 32'(9 + SDEPTH));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/call_return_ctrl.md
# call_return_ctrl

Sequencer that drives the 10-bit return-address stack on behalf of the instruction decoder. CALL pushes a return address and redirects the PC. RET pops the top entry and loads it into the PC. The block sits between the decoder/PC logic and the stack, owns the stack's `enable`/`operation`/`data_in` pins, and reports overflow/underflow instead of letting the stack silently drop a request.

## Interface
Parameters:
- `AW`, 10: address width; matches stack entry width.
- `CW`, 5: width of the shadow depth counter.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `call_req`, in, 1: CALL request, level, four-phase.
- `ret_req`, in, 1: RET request, level, four-phase.
- `call_target`, in, AW: jump target for CALL.
- `ret_addr`, in, AW: return address to push for CALL.
- `stk_enable`, out, 1: stack enable.
- `stk_operation`, out, 1: 1 = push, 0 = pop.
- `stk_data_in`, out, AW: push data.
- `stk_data_out`, in, AW: stack pop data; registered by the stack on the pop edge.
- `stk_full`, in, 1: stack full flag.
- `stk_empty`, in, 1: stack empty flag.
- `pc_load`, out, 1: one-cycle PC load strobe.
- `pc_value`, out, AW: PC load value; valid while `pc_load` = 1, otherwise 0.
- `done`, out, 1: one-cycle request-complete pulse.
- `err_ovf`, out, 1: sticky; set when a CALL is refused because `stk_full` = 1.
- `err_udf`, out, 1: sticky; set when a RET is refused because `stk_empty` = 1.
- `err_clr`, in, 1: synchronous clear of both sticky flags.
- `depth`, out, CW: shadow count of entries pushed minus entries popped.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, PUSH, POP, LOAD, FAULT, RELEASE.
- Transitions out of IDLE:
  - `call_req` = 1 and `stk_full` = 0: latch `call_target` and `ret_addr`, go to PUSH. CALL wins if both requests are high.
  - `call_req` = 1 and `stk_full` = 1: set `err_ovf`, go to FAULT.
  - `ret_req` = 1 (no call) and `stk_empty` = 0: go to POP.
  - `ret_req` = 1 and `stk_empty` = 1: set `err_udf`, go to FAULT.
- PUSH, one cycle:
  - `stk_enable` = 1, `stk_operation` = 1, `stk_data_in` = latched `ret_addr`.
  - `pc_load` = 1, `pc_value` = latched `call_target`, `done` = 1.
  - `depth` += 1. Next state RELEASE.
- POP, one cycle: `stk_enable` = 1, `stk_operation` = 0, `depth` -= 1. Next state LOAD.
- LOAD, one cycle: `pc_load` = 1, `pc_value` = `stk_data_out`, `done` = 1. Next state RELEASE.
- FAULT, one cycle: `done` = 1. No `stk_enable`, no `pc_load`. Next state RELEASE.
- RELEASE: wait until `call_req` = 0 and `ret_req` = 0, then go to IDLE. A request held high is never serviced twice.
- `stk_operation` and `stk_data_in` are 0 whenever `stk_enable` = 0.
- `depth` arithmetic is unsigned CW-bit. It never wraps, because full/empty refusal gates it.
- `err_clr` has priority over a same-cycle set: a simultaneous set is lost.

## Timing
- Reset (`rst_n` = 0, asynchronous): state IDLE; all outputs 0; latches, `depth` and error flags cleared.
- Reset mid-operation aborts with no `done`. The stack is reset by the same event at top level.
- CALL latency: request sampled at edge N; PUSH is cycle N+1 with `pc_load`/`done`; stack write lands at edge N+2.
- RET latency: sampled at edge N; POP is cycle N+1; stack `data_out` is updated at edge N+2; LOAD is cycle N+2 with `pc_load`/`done`.
- Fault latency: `done` in cycle N+1. `err_*` is visible from cycle N+1 onward.
- Minimum request-to-request spacing: requester must drop its request after `done`. The next request can then be sampled one edge after both requests are observed low in RELEASE.
- Full/empty flags are sampled only in IDLE.

## Test plan
- Reset then CALL with `call_target` = 0x155, `ret_addr` = 0x042 -> PUSH cycle shows stack push of 0x042, `pc_load` with 0x155, `done`, `depth` = 1.
- CALL (0x042), then RET -> POP cycle, then LOAD shows `pc_value` = 0x042, `depth` = 0, `stk_empty` = 1 afterwards.
- Three nested CALLs with `ret_addr` 0x010/0x020/0x030, then three RETs -> PC loads 0x030, 0x020, 0x010 in that order.
- RET with empty stack -> no `stk_enable`, `done` in cycle N+1, `err_udf` = 1 until `err_clr`. Fill the stack until `stk_full`, then CALL -> `err_ovf` = 1, `depth` unchanged.
- `call_req` and `ret_req` high together with both held for 5 cycles -> exactly one CALL is serviced, `busy` stays 1 until both requests drop.
- Assert `rst_n` = 0 during POP -> all outputs 0 immediately, no `done`, FSM in IDLE after release.
